// File: rtl/uart_tx_sched_pkg.sv
// Shared types and widths for the UART byte scheduler.
package uart_sched_pkg;

    localparam int unsigned MSG_W  = 32;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_DRAIN
    } sched_state_t;

    function automatic logic [BYTE_W-1:0] byte_at(
        input logic [MSG_W-1:0] msg,
        input logic [LEN_W-1:0] k
    );
        return msg[{k, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshakes plus the serializer-facing signals of uart_tx_sched.
interface uart_tx_sched_if;
    import uart_sched_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [MSG_W-1:0]  req0_data;
    logic [LEN_W-1:0]  req0_len;

    logic              req1_valid;
    logic              req1_ready;
    logic [MSG_W-1:0]  req1_data;
    logic [LEN_W-1:0]  req1_len;

    logic [BYTE_W-1:0] tx_sdata;
    logic              tx_start;
    logic              tx_busy;
    logic              sched_busy;
    logic              grant_id;

    modport slave (
        input  req0_valid, req0_data, req0_len,
        input  req1_valid, req1_data, req1_len,
        input  tx_busy,
        output req0_ready, req1_ready,
        output tx_sdata, tx_start, sched_busy, grant_id
    );

    modport master (
        output req0_valid, req0_data, req0_len,
        output req1_valid, req1_data, req1_len,
        output tx_busy,
        input  req0_ready, req1_ready,
        input  tx_sdata, tx_start, sched_busy, grant_id
    );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant register moves only on update.
module rr_arb2 #(
    parameter bit RESET_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant
);

    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= RESET_LAST;
        end else if (update && grant_valid) begin
            last_grant <= grant;
        end
    end

    // Contention favours whichever requester did not win last time.
    always_comb begin
        grant_valid = |req;
        grant       = (&req) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Grants whole 1-4 byte messages round-robin and feeds them byte-by-byte
// through the uart_tx start/busy handshake.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter bit LSB_FIRST     = 1'b1,
    parameter bit RR_RESET_LAST = 1'b1
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    sched_state_t     state;
    sched_state_t     state_nx;

    logic [MSG_W-1:0] buf_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] idx_q;
    logic             grant_q;

    logic             win_valid;
    logic             win;
    logic             accept;
    logic             byte_done;
    logic [MSG_W-1:0] sel_data;
    logic [LEN_W-1:0] sel_len;

    rr_arb2 #(
        .RESET_LAST(RR_RESET_LAST)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({bus.req1_valid, bus.req0_valid}),
        .update     (accept),
        .grant_valid(win_valid),
        .grant      (win)
    );

    always_comb begin
        accept    = (state == S_IDLE) && win_valid && !rst;
        byte_done = (state == S_DRAIN) && !bus.tx_busy;
        sel_data  = win ? bus.req1_data : bus.req0_data;
        sel_len   = win ? bus.req1_len  : bus.req0_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)       state_nx = S_START;
            S_START: if (!bus.tx_busy) state_nx = S_ACK;
            S_ACK:   if (bus.tx_busy)  state_nx = S_DRAIN;
            S_DRAIN: if (!bus.tx_busy) state_nx = (rem_q != '0) ? S_START : S_IDLE;
            default:                   state_nx = S_IDLE;
        endcase
    end

    // rem_q counts bytes still to send; idx_q walks the byte lanes in send order.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            grant_q <= 1'b0;
        end else if (accept) begin
            buf_q   <= sel_data;
            rem_q   <= sel_len;
            idx_q   <= LSB_FIRST ? '0 : sel_len;
            grant_q <= win;
        end else if (byte_done && (rem_q != '0)) begin
            rem_q <= rem_q - 1'b1;
            idx_q <= LSB_FIRST ? idx_q + 1'b1 : idx_q - 1'b1;
        end
    end

    always_comb begin
        bus.req0_ready = accept && !win;
        bus.req1_ready = accept && win;
        bus.tx_start   = 1'b0;
        bus.tx_sdata   = '0;
        bus.sched_busy = (state != S_IDLE);
        bus.grant_id   = grant_q;
        if ((state == S_START) && !bus.tx_busy) begin
            bus.tx_start = 1'b1;
            bus.tx_sdata = byte_at(buf_q, idx_q);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: serializer model, message-level byte scoreboard, directed and random traffic.
module tb_uart_tx_sched;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  len;
    } msg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    uart_tx_sched_if ifa ();
    uart_tx_sched_if ifb ();

    uart_tx_sched #(.LSB_FIRST(1'b1), .RR_RESET_LAST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    uart_tx_sched #(.LSB_FIRST(1'b0), .RR_RESET_LAST(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Serializer model: busy rises the cycle after a sampled start, lasts a frame, ignores rst.
    logic        force_a = 1'b0;
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    always @(posedge clk) begin
        if (ifa.tx_start) cnt_a <= $urandom_range(2, 9);
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
        if (ifb.tx_start) cnt_b <= 4;
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    end
    assign ifa.tx_busy = force_a || (cnt_a != 0);
    assign ifb.tx_busy = (cnt_b != 0);

    msg_t        pend0[$];
    msg_t        pend1[$];
    msg_t        cur0 = '0;
    msg_t        cur1 = '0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  obs_b[$];
    bit          grant_log[$];
    bit          took0 = 1'b0;
    bit          took1 = 1'b0;
    bit          model_last = 1'b1;
    int unsigned acc0 = 0;
    int unsigned acc1 = 0;
    int unsigned n_start_a = 0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endfunction

    // Monitor A: round-robin winner prediction and expected byte stream per message.
    initial begin : mon_a
        bit         prev_start = 1'b0;
        bit         prev_busy = 1'b0;
        bit         prev_acc = 1'b0;
        bit         prev_win = 1'b0;
        bit         fall_pend = 1'b0;
        bit         pv0 = 1'b0;
        bit         pr0 = 1'b0;
        logic [31:0] pd0 = '0;
        bit         win;
        msg_t       m;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_a.delete();
                grant_log.delete();
                model_last = 1'b1;
                prev_start = 1'b0;
                prev_acc   = 1'b0;
                fall_pend  = 1'b0;
                pv0        = 1'b0;
                prev_busy  = ifa.tx_busy;
            end else begin
                if (pv0 && !pr0) check("req0_payload_stable", ifa.req0_data, pd0);
                if (fall_pend) begin
                    check("sched_busy_after_fall", ifa.sched_busy, exp_a.size() != 0);
                    check("start_after_fall", ifa.tx_start, exp_a.size() != 0);
                end
                if (prev_acc) begin
                    check("grant_id", ifa.grant_id, prev_win);
                    if (!ifa.tx_busy) check("start_latency", ifa.tx_start, 1'b1);
                end
                if (ifa.tx_start) begin
                    check("start_while_busy", ifa.tx_busy, 1'b0);
                    check("start_back_to_back", prev_start, 1'b0);
                    if (exp_a.size() == 0) check("spurious_start", ifa.tx_start, 1'b0);
                    else check("byte", ifa.tx_sdata, exp_a.pop_front());
                    n_start_a++;
                end
                prev_acc = 1'b0;
                if (ifa.req0_ready || ifa.req1_ready) begin
                    win = (ifa.req0_valid && ifa.req1_valid) ? !model_last : ifa.req1_valid;
                    check("ready_winner", {ifa.req1_ready, ifa.req0_ready}, win ? 2'b10 : 2'b01);
                    check("accept_between_messages", exp_a.size(), 0);
                    m = win ? cur1 : cur0;
                    for (int unsigned k = 0; k <= 32'(m.len); k++) exp_a.push_back(m.data[8*k +: 8]);
                    model_last = win;
                    grant_log.push_back(win);
                    if (win) begin took1 = 1'b1; acc1++; end
                    else     begin took0 = 1'b1; acc0++; end
                    prev_acc = 1'b1;
                    prev_win = win;
                end
                fall_pend  = prev_busy && !ifa.tx_busy && !ifa.tx_start;
                prev_busy  = ifa.tx_busy;
                prev_start = ifa.tx_start;
                pv0 = ifa.req0_valid;
                pr0 = ifa.req0_ready;
                pd0 = ifa.req0_data;
            end
        end
    end

    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (!rst && ifb.tx_start) obs_b.push_back(ifb.tx_sdata);
        end
    end

    task automatic present0(input msg_t m);
        cur0 = m;
        ifa.req0_data  = m.data;
        ifa.req0_len   = m.len;
        ifa.req0_valid = 1'b1;
    endtask

    task automatic present1(input msg_t m);
        cur1 = m;
        ifa.req1_data  = m.data;
        ifa.req1_len   = m.len;
        ifa.req1_valid = 1'b1;
    endtask

    task automatic step_a(input bit gaps);
        @(posedge clk);
        #1;
        if (took0) begin took0 = 1'b0; ifa.req0_valid = 1'b0; end
        if (took1) begin took1 = 1'b0; ifa.req1_valid = 1'b0; end
        if (!ifa.req0_valid && pend0.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) present0(pend0.pop_front());
        if (!ifa.req1_valid && pend1.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) present1(pend1.pop_front());
    endtask

    task automatic pump_a(input string tag, input bit gaps, input int unsigned budget);
        bit done = 1'b0;
        for (int unsigned c = 0; c < budget && !done; c++) begin
            step_a(gaps);
            done = !ifa.req0_valid && !ifa.req1_valid && pend0.size() == 0 && pend1.size() == 0
                   && exp_a.size() == 0 && !ifa.sched_busy && !ifa.tx_busy;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic send_b(input msg_t m);
        bit got = 1'b0;
        for (int unsigned j = 0; j <= 32'(m.len); j++) exp_b.push_back(m.data[8*(32'(m.len) - j) +: 8]);
        ifb.req0_data  = m.data;
        ifb.req0_len   = m.len;
        ifb.req0_valid = 1'b1;
        for (int unsigned c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = ifb.req0_ready;
        end
        @(posedge clk);
        #1;
        ifb.req0_valid = 1'b0;
        check("b_accept", got, 1'b1);
    endtask

    initial begin : stim
        msg_t        m;
        int unsigned base;
        int unsigned total;
        bit          reached;
        logic [3:0]  ord;

        ifa.req0_valid = 1'b0; ifa.req0_data = '0; ifa.req0_len = '0;
        ifa.req1_valid = 1'b0; ifa.req1_data = '0; ifa.req1_len = '0;
        ifb.req0_valid = 1'b0; ifb.req0_data = '0; ifb.req0_len = '0;
        ifb.req1_valid = 1'b0; ifb.req1_data = '0; ifb.req1_len = '0;

        // Both requesters valid while reset is held: two len=1 messages each.
        m.data = 32'hFFEE_2010; m.len = 2'd1; present0(m);
        m.data = 32'h7766_4030; m.len = 2'd1; pend0.push_back(m);
        m.data = 32'h5544_B0A0; m.len = 2'd1; present1(m);
        m.data = 32'h3322_D0C0; m.len = 2'd1; pend1.push_back(m);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", ifa.req0_ready, 1'b0);
        check("rst_req1_ready", ifa.req1_ready, 1'b0);
        check("rst_tx_start", ifa.tx_start, 1'b0);
        check("rst_tx_sdata", ifa.tx_sdata, 8'h00);
        check("rst_sched_busy", ifa.sched_busy, 1'b0);
        check("rst_grant_id", ifa.grant_id, 1'b0);
        check("rst_b_sched_busy", ifb.sched_busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        base = n_start_a;
        pump_a("contention", 1'b0, 2000);
        ord = '0;
        for (int unsigned i = 0; i < 4 && i < grant_log.size(); i++) ord[i] = grant_log[i];
        check("contention_grants", grant_log.size(), 4);
        check("contention_order", ord, 4'b1010);
        check("contention_acc0", acc0, 2);
        check("contention_acc1", acc1, 2);
        check("contention_frames", n_start_a - base, 8);

        base = n_start_a;
        m.data = 32'h4433_2211; m.len = 2'd3; pend0.push_back(m);
        pump_a("single", 1'b0, 500);
        check("single_frames", n_start_a - base, 4);

        base = n_start_a;
        m.data = 32'hDEAD_BEEF; m.len = 2'd0; pend1.push_back(m);
        pump_a("short", 1'b0, 500);
        check("short_frames", n_start_a - base, 1);
        check("short_grant_id_idle", ifa.grant_id, 1'b1);

        // Serializer busy from outside; the request arrives while it is still busy.
        force_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        base = n_start_a;
        m.data = 32'h9988_A55A; m.len = 2'd1; present0(m);
        for (int unsigned c = 0; c < 40; c++) step_a(1'b0);
        check("prebusy_no_start", n_start_a - base, 0);
        check("prebusy_waiting", ifa.sched_busy, 1'b1);
        @(posedge clk);
        #1 force_a = 1'b0;
        @(negedge clk);
        check("prebusy_release_start", ifa.tx_start, 1'b1);
        pump_a("prebusy", 1'b0, 500);
        check("prebusy_frames", n_start_a - base, 2);

        // Reset during the second frame of a four-byte message.
        base = n_start_a;
        m.data = $urandom; m.len = 2'd3; pend1.push_back(m);
        reached = 1'b0;
        for (int unsigned c = 0; c < 500 && !reached; c++) begin
            step_a(1'b0);
            reached = (n_start_a - base) >= 2;
        end
        check("midrst_reached", reached, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx_start", ifa.tx_start, 1'b0);
        check("midrst_tx_sdata", ifa.tx_sdata, 8'h00);
        check("midrst_sched_busy", ifa.sched_busy, 1'b0);
        check("midrst_grant_id", ifa.grant_id, 1'b0);
        check("midrst_req_ready", {ifa.req1_ready, ifa.req0_ready}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        m.data = $urandom; m.len = 2'($urandom_range(0, 3)); pend0.push_back(m);
        pump_a("post_reset", 1'b0, 1000);
        check("post_reset_frames", n_start_a - base, 2 + 32'(m.len) + 1);

        // Random traffic from both requesters, garbage above len.
        base = n_start_a;
        total = 0;
        for (int unsigned i = 0; i < 24; i++) begin
            m.data = $urandom;
            m.len  = 2'($urandom_range(0, 3));
            total += 32'(m.len) + 1;
            if ($urandom_range(0, 1) != 0) pend0.push_back(m);
            else pend1.push_back(m);
        end
        pump_a("random", 1'b1, 20000);
        check("random_frames", n_start_a - base, total);

        // MSB-first instance.
        m.data = 32'h00A1_B2C3; m.len = 2'd2; send_b(m);
        m.data = $urandom; m.len = 2'd3; send_b(m);
        m.data = $urandom; m.len = 2'd0; send_b(m);
        reached = 1'b0;
        for (int unsigned c = 0; c < 400 && !reached; c++) begin
            @(negedge clk);
            reached = (obs_b.size() >= exp_b.size()) && !ifb.sched_busy && !ifb.tx_busy;
        end
        check("b_done", reached, 1'b1);
        check("b_frames", obs_b.size(), exp_b.size());
        for (int unsigned i = 0; i < exp_b.size() && i < obs_b.size(); i++) check("b_byte", obs_b[i], exp_b[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Byte scheduler and two-way arbiter in front of the shared `uart_tx` serializer. It accepts 1–4 byte messages from two requesters (core output port and debug/status port) over valid/ready and grants whole messages round-robin. It serializes each message into bytes, one byte per `uart_tx` frame, and sequences the serializer's `tx_start`/`tx_busy` handshake so no byte is dropped or overlapped.

## Interface
Parameters:
- `LSB_FIRST`, 1, byte order within a message: 1 = `data[7:0]` first; 0 = highest valid byte first.
- `RR_RESET_LAST`, 1, value of the last-grant register after reset; 1 gives requester 0 the first grant.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a message.
- `req0_ready`  out  1  requester 0 message accepted this cycle.
- `req0_data`  in  32  requester 0 payload.
- `req0_len`  in  2  requester 0 byte count minus 1 (0..3 → 1..4 bytes).
- `req1_valid`, `req1_ready`, `req1_data`, `req1_len`: same as requester 0, for requester 1.
- `tx_sdata`  out  8  byte to the serializer.
- `tx_start`  out  1  one-cycle start pulse to the serializer.
- `tx_busy`  in  1  serializer busy; rises the cycle after a sampled `tx_start`.
- `sched_busy`  out  1  message in flight (state ≠ S_IDLE).
- `grant_id`  out  1  requester owning the current message; holds the last owner when idle.

## Operation
- States:
  - S_IDLE: wait for a request.
  - S_START: present byte, pulse `tx_start`.
  - S_ACK: wait for `tx_busy` high.
  - S_DRAIN: wait for `tx_busy` low.
- S_IDLE:
  - No valid request: stay.
  - One valid request: grant it.
  - Both valid: grant the requester ≠ `last_grant`.
  - On grant, `reqN_ready`=1 for the winner only (combinational from state and valids). Capture data, len, and id into `buf`, `rem`, and `grant_id`. Set `last_grant` ← winner. Go to S_START.
- S_START:
  - `tx_busy`=1 (serializer still busy from before): `tx_start`=0, stay.
  - `tx_busy`=0: `tx_start`=1 and `tx_sdata` = current byte; go to S_ACK.
- S_ACK: `tx_busy`=1 → S_DRAIN; otherwise stay. `tx_start` is never re-asserted here.
- S_DRAIN: `tx_busy`=0 → advance the byte pointer:
  - `rem`≠0: `rem`−1, go to S_START.
  - `rem`=0: go to S_IDLE.
- Byte selection:
  - LSB_FIRST=1: byte k = `buf[8k+7:8k]`, k counting up from 0.
  - LSB_FIRST=0: k counts down from the captured len.
  - A 2-bit index counter; no shifting of unused upper bytes.
- Bytes above the captured len are never transmitted, regardless of their content.
- Requests are never dropped. A requester holds valid and payload until its ready; payload changes while valid=1 and ready=0 are illegal (bench asserts this).

## Timing
- Reset values:
  - `req0_ready`/`req1_ready`=0, `tx_start`=0, `tx_sdata`=0, `sched_busy`=0, `grant_id`=0.
  - `last_grant`=RR_RESET_LAST, state=S_IDLE.
  - Reset mid-message abandons the remaining bytes. The byte already in the serializer completes on its own. The first post-reset S_START waits for `tx_busy`=0.
- Accept at cycle t (ready&valid) → `tx_start` at t+1 (if `tx_busy`=0) → `tx_busy` seen at t+2.
- Byte-to-byte gap: `tx_busy` falls at cycle u → S_START at u+1 → `tx_start` at u+1. One idle cycle of `txd`=1 is added beyond the serializer's stop bit.
- End of message: `tx_busy` falls at u → S_IDLE at u+1. The next grant can occur at u+1, with `tx_start` at u+2.
- Per-message overhead: zero extra cycles beyond the above. An N-byte message occupies N serializer frames plus (N+1) controller cycles.
- At most one `tx_start` per `tx_busy` rising edge; `tx_start` is never high in two consecutive cycles.
- Both requesters continuously valid: grants alternate 0,1,0,1… per message.

## Structure
- Shared package `uart_sched_pkg`:
  - state enum (`S_IDLE`, `S_START`, `S_ACK`, `S_DRAIN`).
  - `MSG_W`=32, `LEN_W`=2, `BYTE_W`=8.
- One sub-module, `rr_arb2`: two-input round-robin grant with a `last_grant` register and an update-enable. The FSM, byte mux, and counters stay in `uart_tx_sched`.
- The top level instantiates `uart_tx_sched` directly driving `uart_tx` (`sdata`, `tx_start`, `tx_busy`). No other agent drives the serializer.

## Test plan
- Single request: req0 data=0x44332211, len=3, LSB_FIRST=1 → serializer bytes 0x11, 0x22, 0x33, 0x44 in order; `sched_busy` returns to 0 one cycle after the 4th `tx_busy` fall.
- Short message: req1 data=0xDEADBEEF, len=0 → exactly one frame, 0xEF; `grant_id`=1.
- Contention: req0 and req1 both valid from reset, each len=1 → order req0 bytes, req1 bytes, req0, req1; each ready pulses exactly once per message.
- Byte order: LSB_FIRST=0, data=0x00A1B2C3, len=2 → 0xC3 is not first; sequence 0xA1, 0xB2, 0xC3.
- Serializer pre-busy: hold `tx_busy`=1 externally for 50 cycles, then raise req0 → no `tx_start` until `tx_busy` falls; then `tx_start` on the next cycle.
- Reset mid-message: assert `rst` after byte 2 of 4 → outputs return to reset values next cycle; no further `tx_start` from that message; a new req0 after reset transmits normally.
